// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key schedule and its round datapath.
package aes_pkg;

  localparam int AES_NR   = 10;
  localparam int AES_NK   = 4;
  localparam int AES_RK_W = 128;

  // Index r gives the round constant for round r; entry 0 is unused.
  localparam logic [10:0][7:0] AES_RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  typedef logic [0:0] aes_kx_state_t;
  localparam aes_kx_state_t IDLE   = 1'b0;
  localparam aes_kx_state_t EXPAND = 1'b1;

  typedef logic [0:AES_RK_W-1] aes_rk_t;
  typedef aes_rk_t aes_rk_array_t [0:AES_NR];

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry register file.
// Optional AES_KEYEXP_ZEROIZE_EN adds a zeroize input that wipes all stored keys.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key
);

  aes_kx_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  aes_rk_t       rk_q [0:NR];
  aes_rk_t       rk_d [0:NR];

  aes_rk_t       prev_rk;
  aes_rk_t       next_rk;
  logic [0:31]   rot_w3;
  logic [0:31]   sub_w;
  logic [0:31]   t_w;
  logic [0:31]   w4, w5, w6, w7;
  logic [7:0]    rcon_byte;

  // The previous round key is selected by the counter, which names the key being written.
  always_comb begin
    prev_rk = '0;
    for (int i = 1; i <= NR; i++) begin
      if (cnt_q == 4'(i)) prev_rk = rk_q[i-1];
    end
  end

  assign rot_w3 = {prev_rk[104:127], prev_rk[96:103]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_byte  (rot_w3[gi*8 +: 8]),
        .out_byte (sub_w[gi*8 +: 8])
      );
    end
  endgenerate

  assign rcon_byte = AES_RCON[cnt_q];
  assign t_w       = sub_w ^ {rcon_byte, 24'h0};
  assign w4        = prev_rk[0:31]   ^ t_w;
  assign w5        = prev_rk[32:63]  ^ w4;
  assign w6        = prev_rk[64:95]  ^ w5;
  assign w7        = prev_rk[96:127] ^ w6;
  assign next_rk   = {w4, w5, w6, w7};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    for (int i = 0; i <= NR; i++) rk_d[i] = rk_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d[0] = key_in;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = EXPAND;
        end
      end
      default: begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == 4'(i)) rk_d[i] = next_rk;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
    endcase

`ifdef AES_KEYEXP_ZEROIZE_EN
    if (zeroize) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      valid_d = 1'b0;
      for (int i = 0; i <= NR; i++) rk_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rk_q[gi] <= '0;
        else        rk_q[gi] <= rk_d[gi];
      end
    end
  endgenerate

  // Indices past the last round read as zero rather than aliasing into storage.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rd_key = rk_q[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, corner sequences and
// random keys against a GF(2^8)-derived reference key schedule.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key_in;
  logic         busy, done, keys_valid;
  logic [3:0]   rd_idx;
  logic [0:127] rd_key;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_ref [0:255];
  logic [127:0] ref_rk   [0:10];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_ref[x] = s;
    end
  endtask

  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_key(input int idx, output logic [127:0] k);
    rd_idx = 4'(idx);
    #1;
    k = rd_key;
  endtask

  // Pulses start for one cycle; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expand_and_check_latency(input logic [127:0] k, input string tag);
    int lat;
    pulse_start(k);
    check1({tag, " busy_after_start"}, busy, 1'b1);
    wait_done(lat);
    check_int({tag, " done_latency"}, lat, 10);
    $display("expand %s key=%h latency=%0d", tag, k, lat);
    check1({tag, " keys_valid"}, keys_valid, 1'b1);
    @(negedge clk);
    check1({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] k, rkey;
    int           lat, ndone;

    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    build_sbox();

    vecs[0] = '{FIPS_KEY, 0,  FIPS_KEY, "fips_rk0"};
    vecs[1] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1"};
    vecs[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10"};
    vecs[3] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363, "zero_rk1"};
    vecs[4] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10"};
    vecs[5] = '{ZERO_KEY, 12, 128'h0, "zero_idx12"};

    // Reset state
    repeat (2) @(negedge clk);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset keys_valid", keys_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    read_key(5, rkey);
    check128("reset rk5", rkey, 128'h0);

    // Table-driven known-answer vectors
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || vecs[i].key != vecs[i-1].key) expand_and_check_latency(vecs[i].key, vecs[i].name);
      read_key(vecs[i].idx, rkey);
      $display("read %s idx=%0d key=%h", vecs[i].name, vecs[i].idx, rkey);
      check128(vecs[i].name, rkey, vecs[i].exp);
    end

    // start re-pulsed mid-expansion must be ignored
    pulse_start(FIPS_KEY);
    ndone = 0; lat = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3 || c == 7) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = c;
      end
    end
    start = 1'b0;
    $display("repulse done_count=%0d latency=%0d", ndone, lat);
    check_int("repulse done_count", ndone, 1);
    check_int("repulse latency", lat, 10);
    ref_expand(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      read_key(r, rkey);
      check128($sformatf("repulse rk%0d", r), rkey, ref_rk[r]);
    end

    // Asynchronous reset mid-expansion
    pulse_start(FIPS_KEY);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("midreset busy", busy, 1'b0);
    check1("midreset done", done, 1'b0);
    check1("midreset keys_valid", keys_valid, 1'b0);
    for (int r = 0; r <= 10; r++) begin
      read_key(r, rkey);
      check128($sformatf("midreset rk%0d", r), rkey, 128'h0);
    end
    $display("midreset applied, keys cleared");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: new start in the done cycle
    pulse_start(FIPS_KEY);
    wait_done(lat);
    check_int("b2b first latency", lat, 10);
    start  = 1'b1;
    key_in = ZERO_KEY;
    @(negedge clk);
    start  = 1'b0;
    check1("b2b keys_valid_drop", keys_valid, 1'b0);
    check1("b2b busy", busy, 1'b1);
    wait_done(lat);
    $display("b2b second latency=%0d", lat);
    check_int("b2b second latency", lat, 10);
    ref_expand(ZERO_KEY);
    for (int r = 0; r <= 10; r++) begin
      read_key(r, rkey);
      check128($sformatf("b2b rk%0d", r), rkey, ref_rk[r]);
    end
    read_key(12, rkey);
    check128("b2b idx12", rkey, 128'h0);
    @(negedge clk);

    // Random keys against the reference schedule
    for (int n = 0; n < 12; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      ref_expand(k);
      expand_and_check_latency(k, $sformatf("rand%0d", n));
      for (int r = 0; r <= 10; r++) begin
        read_key(r, rkey);
        check128($sformatf("rand%0d rk%0d", n, r), rkey, ref_rk[r]);
      end
      read_key(11 + int'($urandom_range(0, 4)), rkey);
      check128($sformatf("rand%0d out_of_range", n), rkey, 128'h0);
    end

`ifdef AES_KEYEXP_ZEROIZE_EN
    // Zeroize mid-expansion, then a normal run
    pulse_start(FIPS_KEY);
    repeat (3) @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check1("zeroize busy", busy, 1'b0);
    check1("zeroize keys_valid", keys_valid, 1'b0);
    for (int r = 0; r <= 10; r++) begin
      read_key(r, rkey);
      check128($sformatf("zeroize rk%0d", r), rkey, 128'h0);
    end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    $display("zeroize done_count=%0d", ndone);
    check_int("zeroize no_done", ndone, 0);
    expand_and_check_latency(FIPS_KEY, "post_zeroize");
    read_key(10, rkey);
    check128("post_zeroize rk10", rkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
